// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared op codes, state encoding and partial-product combine for the multiply sequencer
//
// Purpose:
//   Types and helpers shared by the 32x32 multiply sequencer and anything
//   that needs to decode its op field.
// Contents:
//   OP_MUL / OP_MULXUU / OP_MULXSU / OP_MULXSS  2-bit operation codes
//   state_t                                     sequencer state encoding
//   lo_combine()                                p1 + ((p2 + p3) << 16), 49 bits

package mul_seq_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PASS_LO = 3'd1,
    PASS_HI = 3'd2,
    FIX     = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Low-pass accumulation. The cross terms are summed at 33 bits before the
  // shift so their carry reaches bit 48. Bit 48 is the top of the window:
  // a_lo*b_lo + (a_lo*b_hi + a_hi*b_lo)*2^16 < 2^49.
  function automatic logic [48:0] lo_combine(input logic [31:0] p1,
                                             input logic [31:0] p2,
                                             input logic [31:0] p3);
    logic [32:0] mid;
    mid = {1'b0, p2} + {1'b0, p3};
    return {17'b0, p1} + {mid, 16'b0};
  endfunction

endpackage

// File: rtl/de0_nano_sopc_cpu_mul_seq.sv
// rtl/de0_nano_sopc_cpu_mul_seq.sv - multi-pass 32x32 multiply sequencer around a 16x16 three-product cell
//
// Purpose:
//   Accepts one multiply request at a time. It runs a low pass on the full
//   operands, and for MULX ops a second pass on the upper halves. It then
//   sign-corrects the high word and holds the result until the consumer
//   takes it.
// Parameters:
//   CELL_LATENCY  cycles from a sampled cell_en to valid cell_p* (1..3)
// Ports:
//   clk, reset_n                   clock, synchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_op, req_a, req_b           operation and operands, latched on accept
//   rsp_valid/rsp_ready            response handshake
//   rsp_result                     low (MUL) or high (MULX*) product word
//   cell_src1, cell_src2, cell_en  drive to the multiplier cell
//   cell_p1, cell_p2, cell_p3      partial products from the cell

module de0_nano_sopc_cpu_mul_seq
  import mul_seq_pkg::*;
#(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  // The count runs CELL_LATENCY..0, so a pass lasts CELL_LATENCY+1 cycles.
  // Products are sampled when the count reaches zero.
  localparam logic [1:0] CNT_LOAD = 2'(CELL_LATENCY);

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [1:0]  r_op;
  logic [48:0] r_lo_acc;
  logic [31:0] r_hh;
  logic [31:0] r_result;

  logic        w_cnt_zero;
  logic        w_is_mul;
  logic [48:0] w_lo_acc;
  logic [31:0] w_hi_raw;
  logic [31:0] w_sub_a;
  logic [31:0] w_sub_b;
  logic [31:0] w_hi;

  assign w_cnt_zero = (r_cnt == 2'd0);
  assign w_is_mul   = (r_op == OP_MUL);
  assign w_lo_acc   = lo_combine(cell_p1, cell_p2, cell_p3);

  // Unsigned high word: a_hi*b_hi plus the carry-out of the low window.
  assign w_hi_raw = r_hh + {15'b0, r_lo_acc[48:32]};

  // Signed corrections. A negative a adds -2^32*b to the unsigned product.
  // A negative b adds -2^32*a. Only the high word sees either term.
  assign w_sub_a = ((r_op == OP_MULXSU || r_op == OP_MULXSS) && r_a[31]) ? r_b : 32'h0;
  assign w_sub_b = ((r_op == OP_MULXSS) && r_b[31]) ? r_a : 32'h0;
  assign w_hi    = w_hi_raw - w_sub_a - w_sub_b;

  assign rsp_result = r_result;

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    cell_en      = 1'b0;
    cell_src1    = 32'h0;
    cell_src2    = 32'h0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next_state = PASS_LO;
        end
      end
      PASS_LO: begin
        cell_en   = 1'b1;
        cell_src1 = r_a;
        cell_src2 = r_b;
        if (w_cnt_zero) begin
          w_next_state = w_is_mul ? DONE : PASS_HI;
        end
      end
      PASS_HI: begin
        // Only p1 is used here. It yields a_hi*b_hi.
        cell_en   = 1'b1;
        cell_src1 = {16'h0, r_a[31:16]};
        cell_src2 = {16'h0, r_b[31:16]};
        if (w_cnt_zero) begin
          w_next_state = FIX;
        end
      end
      FIX: begin
        w_next_state = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= 2'd0;
      r_a      <= 32'h0;
      r_b      <= 32'h0;
      r_op     <= OP_MUL;
      r_lo_acc <= 49'h0;
      r_hh     <= 32'h0;
      r_result <= 32'h0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_a   <= req_a;
            r_b   <= req_b;
            r_op  <= req_op;
            r_cnt <= CNT_LOAD;
          end
        end
        PASS_LO: begin
          if (w_cnt_zero) begin
            r_lo_acc <= w_lo_acc;
            r_cnt    <= CNT_LOAD;
            if (w_is_mul) begin
              r_result <= w_lo_acc[31:0];
            end
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        PASS_HI: begin
          if (w_cnt_zero) begin
            r_hh <= cell_p1;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        FIX: begin
          r_result <= w_hi;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_de0_nano_sopc_cpu_mul_seq.sv
// tb/tb_de0_nano_sopc_cpu_mul_seq.sv - scoreboard bench for the multiply sequencer at cell latencies 1 and 3

module tb_de0_nano_sopc_cpu_mul_seq;
  import mul_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Index 0: CELL_LATENCY=1, index 1: CELL_LATENCY=3
  logic        reset_n    [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [1:0]  req_op     [2];
  logic [31:0] req_a      [2];
  logic [31:0] req_b      [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_result [2];
  logic [31:0] cell_src1  [2];
  logic [31:0] cell_src2  [2];
  logic        cell_en    [2];
  logic [31:0] cell_p1    [2];
  logic [31:0] cell_p2    [2];
  logic [31:0] cell_p3    [2];

  de0_nano_sopc_cpu_mul_seq #(.CELL_LATENCY(1)) dut_l1 (
    .clk(clk), .reset_n(reset_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_a(req_a[0]), .req_b(req_b[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
    .cell_src1(cell_src1[0]), .cell_src2(cell_src2[0]), .cell_en(cell_en[0]),
    .cell_p1(cell_p1[0]), .cell_p2(cell_p2[0]), .cell_p3(cell_p3[0])
  );

  de0_nano_sopc_cpu_mul_seq #(.CELL_LATENCY(3)) dut_l3 (
    .clk(clk), .reset_n(reset_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_a(req_a[1]), .req_b(req_b[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
    .cell_src1(cell_src1[1]), .cell_src2(cell_src2[1]), .cell_en(cell_en[1]),
    .cell_p1(cell_p1[1]), .cell_p2(cell_p2[1]), .cell_p3(cell_p3[1])
  );

  // Behavioural cell: products enter stage 0 on an enabled edge and then
  // shift one stage per clock. The output tap sets the latency.
  logic [31:0] c1 [2][3];
  logic [31:0] c2 [2][3];
  logic [31:0] c3 [2][3];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cell_en[i]) begin
        c1[i][0] <= {16'h0, cell_src1[i][15:0]}  * {16'h0, cell_src2[i][15:0]};
        c2[i][0] <= {16'h0, cell_src1[i][15:0]}  * {16'h0, cell_src2[i][31:16]};
        c3[i][0] <= {16'h0, cell_src1[i][31:16]} * {16'h0, cell_src2[i][15:0]};
      end
      for (int k = 1; k < 3; k++) begin
        c1[i][k] <= c1[i][k-1];
        c2[i][k] <= c2[i][k-1];
        c3[i][k] <= c3[i][k-1];
      end
    end
  end

  assign cell_p1[0] = c1[0][0];
  assign cell_p2[0] = c2[0][0];
  assign cell_p3[0] = c3[0][0];
  assign cell_p1[1] = c1[1][2];
  assign cell_p2[1] = c2[1][2];
  assign cell_p3[1] = c3[1][2];

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_res_q [2][$];
  int          exp_lat_q [2][$];
  string       exp_nm_q  [2][$];

  int acc_t   [2];
  int first_v [2];
  int en_cyc  [2];
  bit prev_v  [2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", nm);
  endtask

  // Monitor: records accept and first-valid cycles. On each response
  // handshake it pops the scoreboard and checks the result word and latency.
  initial begin
    for (int i = 0; i < 2; i++) begin
      acc_t[i] = 0; first_v[i] = 0; en_cyc[i] = 0; prev_v[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (cell_en[i] === 1'b1) en_cyc[i]++;
        if (req_valid[i] && req_ready[i] && reset_n[i]) acc_t[i] = cyc;
        if (rsp_valid[i] && !prev_v[i]) first_v[i] = cyc;
        prev_v[i] = rsp_valid[i];
        if (rsp_valid[i] === 1'b1 && rsp_ready[i] === 1'b1) begin
          if (exp_res_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp inst%0d: got 0x%08h expected no response", i, rsp_result[i]);
          end else begin
            logic [31:0] r;
            int          l;
            string       nm;
            r  = exp_res_q[i].pop_front();
            l  = exp_lat_q[i].pop_front();
            nm = exp_nm_q[i].pop_front();
            check(nm, rsp_result[i], r);
            check({nm, "_latency"}, 32'(first_v[i] - acc_t[i]), 32'(l));
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input int i, input string nm);
    check({nm, "_req_ready"},  {31'h0, req_ready[i]}, 32'h1);
    check({nm, "_rsp_valid"},  {31'h0, rsp_valid[i]}, 32'h0);
    check({nm, "_rsp_result"}, rsp_result[i],         32'h0);
    check({nm, "_cell_en"},    {31'h0, cell_en[i]},   32'h0);
    check({nm, "_cell_src1"},  cell_src1[i],          32'h0);
    check({nm, "_cell_src2"},  cell_src2[i],          32'h0);
  endtask

  // Entered and left just after a rising edge. Returns once accepted.
  task automatic wait_accept(input int i, input string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1'b1;
    end
    if (!ok) timeout({nm, "_accept"});
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input string nm);
    exp_res_q[i].push_back(exp);
    exp_lat_q[i].push_back(lat);
    exp_nm_q[i].push_back(nm);
    req_op[i]    = op;
    req_a[i]     = a;
    req_b[i]     = b;
    req_valid[i] = 1'b1;
    wait_accept(i, nm);
    // Operands change while busy; the latched copies must be used.
    req_valid[i] = 1'b0;
    req_a[i]     = $urandom;
    req_b[i]     = $urandom;
  endtask

  task automatic drain(input int i, input string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (exp_res_q[i].size() == 0) ok = 1'b1;
    end
    if (!ok) timeout({nm, "_response"});
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int i, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat,
                     input string nm);
    issue(i, op, a, b, exp, lat, nm);
    drain(i, nm);
  endtask

  initial begin
    int  t;
    bit  ok;
    for (int i = 0; i < 2; i++) begin
      reset_n[i]   = 1'b0;
      req_valid[i] = 1'b0;
      req_op[i]    = OP_MUL;
      req_a[i]     = 32'h0;
      req_b[i]     = 32'h0;
      rsp_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(0, "reset_l1");
    check_reset_outputs(1, "reset_l3");
    @(posedge clk);
    #1;
    reset_n[0] = 1'b1;
    reset_n[1] = 1'b1;

    // Latency 1: directed vectors
    en_cyc[0] = 0;
    run(0, OP_MUL, 32'h00010003, 32'h00020005, 32'h000B000F, 3, "mul_l1");
    check("mul_l1_cell_en_cycles", 32'(en_cyc[0]), 32'd2);
    run(0, OP_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 6, "mulxuu_ff_l1");
    run(0, OP_MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 6, "mulxss_ff_l1");
    run(0, OP_MULXSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 6, "mulxsu_ff_l1");
    run(0, OP_MULXSS, 32'h80000000, 32'h80000000, 32'h40000000, 6, "mulxss_min_l1");
    run(0, OP_MULXSU, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 6, "mulxsu_min_l1");

    // Backpressure: result held for 10 cycles, no request accepted meanwhile
    rsp_ready[0] = 1'b0;
    issue(0, OP_MUL, 32'h00010003, 32'h00020005, 32'h000B000F, 3, "bp_mul");
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (rsp_valid[0]) ok = 1'b1;
    end
    if (!ok) timeout("bp_valid");
    req_valid[0] = 1'b1;
    req_op[0]    = OP_MULXSS;
    req_a[0]     = 32'hDEADBEEF;
    req_b[0]     = 32'hCAFEF00D;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'h0, rsp_valid[0]}, 32'h1);
      check("bp_rsp_result", rsp_result[0], 32'h000B000F);
      check("bp_req_ready", {31'h0, req_ready[0]}, 32'h0);
    end
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b1;
    exp_res_q[0].push_back(32'h23456780);
    exp_lat_q[0].push_back(3);
    exp_nm_q[0].push_back("bp_next_mul");
    req_op[0] = OP_MUL;
    req_a[0]  = 32'h12345678;
    req_b[0]  = 32'h00000010;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_idle", {31'h0, req_ready[0]}, 32'h1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    drain(0, "bp_next_mul");

    // Reset during the high pass: nothing must come out
    req_op[0]    = OP_MULXUU;
    req_a[0]     = 32'hABCD1234;
    req_b[0]     = 32'h56789ABC;
    req_valid[0] = 1'b1;
    t  = 0;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        ok = 1'b1;
        t  = cyc;
      end
    end
    if (!ok) timeout("rst_accept");
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    while (cyc < t + 3) @(negedge clk);
    check("rst_pass_hi_src1", cell_src1[0], 32'h0000ABCD);
    check("rst_pass_hi_src2", cell_src2[0], 32'h00005678);
    check("rst_pass_hi_en", {31'h0, cell_en[0]}, 32'h1);
    reset_n[0] = 1'b0;
    @(negedge clk);
    check_reset_outputs(0, "rst_mid");
    @(posedge clk);
    #1;
    reset_n[0] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    run(0, OP_MUL, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 3, "post_rst_mul");

    // Latency 3
    en_cyc[1] = 0;
    run(1, OP_MUL, 32'h00010003, 32'h00020005, 32'h000B000F, 5, "mul_l3");
    check("mul_l3_cell_en_cycles", 32'(en_cyc[1]), 32'd4);
    run(1, OP_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 10, "mulxuu_ff_l3");
    run(1, OP_MULXSS, 32'h80000000, 32'h80000000, 32'h40000000, 10, "mulxss_min_l3");

    repeat (5) @(posedge clk);
    check("sb_empty_l1", 32'(exp_res_q[0].size()), 32'd0);
    check("sb_empty_l3", 32'(exp_res_q[1].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
